// File: rtl/uart_asm_pkg.sv
// Shared definitions for the UART word assembler.
//   asm_state_t       : assembler state (HUNT for a sync header, COLLECT bytes)
//   DEFAULT_SYNC_BYTE : default frame header value
//   clog2()           : ceiling log2, used to size counters and FIFO pointers
package uart_asm_pkg;

  typedef enum logic {
    HUNT    = 1'b0,
    COLLECT = 1'b1
  } asm_state_t;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/word_fifo.sv
// Synchronous first-word-fall-through FIFO for assembled words.
// Ports:
//   clk, reset_n : clock, synchronous active-low reset
//   push, din    : write request and data (accepted when not full, or when a
//                  pop happens in the same cycle)
//   pop          : read request (ignored when empty)
//   full, empty  : occupancy flags
//   head         : oldest word; driven to zero while empty
module word_fifo
  import uart_asm_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Zeroing the head while empty gives a clean all-zero output after reset
  // without having to reset the storage array.
  assign head = empty ? '0 : mem[rd_ptr];

  // NOTE: state updates use non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers and count
  // define which entries are meaningful, and an unreset array maps to plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_word_assembler.sv
// Collects single-cycle UART byte strobes into BYTES_PER_WORD-byte words,
// optionally framed by a sync header, and buffers completed words in a FIFO.
// Ports:
//   clk, reset_n        : clock, synchronous active-low reset
//   rx_data, rx_valid   : received byte and its one-cycle strobe
//   clear               : clears overflow and drop_cnt
//   word_data/valid     : FIFO head word and not-empty flag
//   word_ready          : consumer accepts the head word this cycle
//   busy                : partial word in progress (or header received)
//   timeout_err         : one-cycle pulse when a partial frame is discarded
//   overflow, drop_cnt  : sticky drop flag and saturating drop counter
module uart_word_assembler
  import uart_asm_pkg::*;
#(
  parameter int         BYTES_PER_WORD = 2,
  parameter bit         MSB_FIRST      = 1'b1,
  parameter bit         SYNC_EN        = 1'b0,
  parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
  parameter int         TIMEOUT_CYC    = 100000,
  parameter int         FIFO_DEPTH     = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [7:0]                  rx_data,
  input  logic                        rx_valid,
  input  logic                        clear,
  output logic [8*BYTES_PER_WORD-1:0] word_data,
  output logic                        word_valid,
  input  logic                        word_ready,
  output logic                        busy,
  output logic                        timeout_err,
  output logic                        overflow,
  output logic [7:0]                  drop_cnt
);

  localparam int WORD_W = 8 * BYTES_PER_WORD;
  localparam int CNT_W  = (clog2(BYTES_PER_WORD) < 1) ? 1 : clog2(BYTES_PER_WORD);
  localparam int TMR_W  = (clog2(TIMEOUT_CYC + 1) < 1) ? 1 : clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BYTES_PER_WORD - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = (TIMEOUT_CYC > 0) ? TMR_W'(TIMEOUT_CYC - 1) : '0;
  localparam asm_state_t       IDLE_ST  = SYNC_EN ? HUNT : COLLECT;

  asm_state_t        state_q;
  logic [CNT_W-1:0]  count_q;
  logic [WORD_W-1:0] word_q;
  logic [WORD_W-1:0] word_next;
  logic [TMR_W-1:0]  timer_q;

  logic push_req;
  logic pop;
  logic drop;
  logic fifo_full;
  logic fifo_empty;
  logic timeout_hit;

  // In sync mode a received header already counts as a frame in progress.
  assign busy = (state_q == COLLECT) && (SYNC_EN || (count_q != '0));

  // A byte arriving in the expiry cycle takes priority over the timeout.
  assign timeout_hit = (TIMEOUT_CYC > 0) && busy && !rx_valid && (timer_q == TMR_LAST);

  assign push_req   = (state_q == COLLECT) && rx_valid && (count_q == LAST_IDX);
  assign word_valid = !fifo_empty;
  assign pop        = word_valid && word_ready;
  assign drop       = push_req && fifo_full && !pop;

  // Current word with the incoming byte placed in its lane; on the last byte
  // this is the word pushed into the FIFO in the same cycle.
  // NOTE: the default assignment first keeps this combinational block from
  // inferring a latch when no lane matches.
  always_comb begin
    word_next = word_q;
    for (int k = 0; k < BYTES_PER_WORD; k++) begin
      if (int'(count_q) == k) begin
        if (MSB_FIRST) word_next[8*(BYTES_PER_WORD-k)-1 -: 8] = rx_data;
        else           word_next[8*k+7 -: 8]                  = rx_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE_ST;
      count_q     <= '0;
      word_q      <= '0;
      timer_q     <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      unique case (state_q)
        HUNT: begin
          if (rx_valid && (rx_data == SYNC_BYTE)) begin
            state_q <= COLLECT;
            count_q <= '0;
          end
        end
        COLLECT: begin
          if (rx_valid) begin
            word_q <= word_next;
            if (count_q == LAST_IDX) begin
              count_q <= '0;
              state_q <= IDLE_ST;
            end else begin
              count_q <= count_q + CNT_W'(1);
            end
          end else if (timeout_hit) begin
            count_q     <= '0;
            state_q     <= IDLE_ST;
            timeout_err <= 1'b1;
          end
        end
        default: state_q <= IDLE_ST;
      endcase

      if (rx_valid || !busy || timeout_hit) timer_q <= '0;
      else if (TIMEOUT_CYC > 0)             timer_q <= timer_q + TMR_W'(1);
    end
  end

  // A drop coinciding with clear leaves exactly that one drop recorded.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clear) begin
      overflow <= drop;
      drop_cnt <= drop ? 8'd1 : 8'd0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  word_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push_req),
    .din     (word_next),
    .pop     (pop),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (word_data)
  );

endmodule

// File: tb/tb_uart_word_assembler.sv
module tb_uart_word_assembler;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       clear = 1'b0;
  logic       word_ready = 1'b0;

  // A: 16-bit MSB-first, timeout 50, depth 4
  logic [15:0] wd_a;
  logic        wv_a, busy_a, to_a, ovf_a;
  logic [7:0]  dc_a;
  // B: 32-bit LSB-first, timeout disabled
  logic [31:0] wd_b;
  logic        wv_b, busy_b, to_b, ovf_b;
  logic [7:0]  dc_b;
  // C: 16-bit MSB-first with sync header, timeout 50, depth 2
  logic [15:0] wd_c;
  logic        wv_c, busy_c, to_c, ovf_c;
  logic [7:0]  dc_c;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  uart_word_assembler #(
    .BYTES_PER_WORD(2), .MSB_FIRST(1'b1), .SYNC_EN(1'b0),
    .TIMEOUT_CYC(50), .FIFO_DEPTH(4)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .clear(clear), .word_data(wd_a), .word_valid(wv_a), .word_ready(word_ready),
    .busy(busy_a), .timeout_err(to_a), .overflow(ovf_a), .drop_cnt(dc_a)
  );

  uart_word_assembler #(
    .BYTES_PER_WORD(4), .MSB_FIRST(1'b0), .SYNC_EN(1'b0),
    .TIMEOUT_CYC(0), .FIFO_DEPTH(4)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .clear(clear), .word_data(wd_b), .word_valid(wv_b), .word_ready(word_ready),
    .busy(busy_b), .timeout_err(to_b), .overflow(ovf_b), .drop_cnt(dc_b)
  );

  uart_word_assembler #(
    .BYTES_PER_WORD(2), .MSB_FIRST(1'b1), .SYNC_EN(1'b1), .SYNC_BYTE(8'hA5),
    .TIMEOUT_CYC(50), .FIFO_DEPTH(2)
  ) dut_c (
    .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .clear(clear), .word_data(wd_c), .word_valid(wv_c), .word_ready(word_ready),
    .busy(busy_c), .timeout_err(to_c), .overflow(ovf_c), .drop_cnt(dc_c)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock with the given byte strobe; returns #1 after the edge.
  task automatic cyc(input logic v, input logic [7:0] d);
    rx_valid = v;
    rx_data  = d;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    rx_valid   = 1'b0;
    clear      = 1'b0;
    word_ready = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // Table of single-cycle vectors for instance A.
  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        rdy;
    logic        exp_valid;
    logic [15:0] exp_data;
    logic        exp_busy;
  } vec_t;

  vec_t vecs[7];

  // Reference model for instance A: frame bytes in a queue, words in a queue.
  logic [7:0]  m_part[$];
  logic [15:0] m_q[$];
  int          m_idle;
  bit          m_to;
  bit          m_ovf;
  int          m_drop;

  task automatic model_step(input bit v, input logic [7:0] d, input bit rdy, input bit clr);
    bit          push;
    bit          dropped;
    logic [15:0] w;
    push    = 1'b0;
    dropped = 1'b0;
    w       = '0;
    m_to    = 1'b0;
    if (v) begin
      m_part.push_back(d);
      m_idle = 0;
      if (m_part.size() == 2) begin
        w = 16'(m_part[0]) * 16'd256 + 16'(m_part[1]);
        m_part.delete();
        push = 1'b1;
      end
    end else if (m_part.size() > 0) begin
      m_idle++;
      if (m_idle == 50) begin
        m_part.delete();
        m_idle = 0;
        m_to   = 1'b1;
      end
    end
    if (rdy && m_q.size() > 0) void'(m_q.pop_front());
    if (push) begin
      if (m_q.size() < 4) m_q.push_back(w);
      else dropped = 1'b1;
    end
    if (clr) begin
      m_ovf  = dropped;
      m_drop = dropped ? 1 : 0;
    end else if (dropped) begin
      m_ovf = 1'b1;
      if (m_drop < 255) m_drop++;
    end
  endtask

  initial begin
    bit saw;
    int pv;
    int pr;

    vecs[0] = '{1'b1, 8'h12, 1'b1, 1'b0, 16'h0000, 1'b1};
    vecs[1] = '{1'b1, 8'h34, 1'b1, 1'b1, 16'h1234, 1'b0};
    vecs[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 16'h0000, 1'b0};
    vecs[3] = '{1'b1, 8'hBE, 1'b0, 1'b0, 16'h0000, 1'b1};
    vecs[4] = '{1'b1, 8'hEF, 1'b0, 1'b1, 16'hBEEF, 1'b0};
    vecs[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 16'hBEEF, 1'b0};
    vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 16'h0000, 1'b0};

    // Reset state
    do_reset();
    check("rst wv_a", 32'(wv_a), 32'd0);
    check("rst wd_a", 32'(wd_a), 32'd0);
    check("rst busy_a", 32'(busy_a), 32'd0);
    check("rst to_a", 32'(to_a), 32'd0);
    check("rst ovf_a", 32'(ovf_a), 32'd0);
    check("rst dc_a", 32'(dc_a), 32'd0);
    check("rst wd_b", wd_b, 32'd0);
    check("rst busy_c", 32'(busy_c), 32'd0);
    check("rst wv_c", 32'(wv_c), 32'd0);

    // Basic MSB-first assembly and handshake, table driven
    for (int i = 0; i < 7; i++) begin
      word_ready = vecs[i].rdy;
      cyc(vecs[i].v, vecs[i].d);
      check($sformatf("vec%0d valid", i), 32'(wv_a), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) check($sformatf("vec%0d data", i), 32'(wd_a), 32'(vecs[i].exp_data));
      check($sformatf("vec%0d busy", i), 32'(busy_a), 32'(vecs[i].exp_busy));
    end

    // 4-byte LSB-first assembly; disabled timeout never fires
    do_reset();
    cyc(1'b1, 8'h01);
    cyc(1'b1, 8'h02);
    cyc(1'b1, 8'h03);
    check("b busy mid", 32'(busy_b), 32'd1);
    check("b valid mid", 32'(wv_b), 32'd0);
    cyc(1'b1, 8'h04);
    check("b valid", 32'(wv_b), 32'd1);
    check("b data", wd_b, 32'h04030201);
    check("b busy end", 32'(busy_b), 32'd0);
    cyc(1'b1, 8'h55);
    saw = 1'b0;
    repeat (120) begin
      cyc(1'b0, 8'h00);
      if (to_b) saw = 1'b1;
    end
    check("b no timeout", 32'(saw), 32'd0);
    check("b still busy", 32'(busy_b), 32'd1);

    // Sync header framing
    do_reset();
    word_ready = 1'b1;
    cyc(1'b1, 8'h77);
    check("c busy after 77", 32'(busy_c), 32'd0);
    cyc(1'b1, 8'hA5);
    check("c busy after A5", 32'(busy_c), 32'd1);
    cyc(1'b1, 8'h10);
    check("c busy after 10", 32'(busy_c), 32'd1);
    check("c valid after 10", 32'(wv_c), 32'd0);
    cyc(1'b1, 8'h20);
    check("c busy after 20", 32'(busy_c), 32'd0);
    check("c valid", 32'(wv_c), 32'd1);
    check("c data", 32'(wd_c), 32'h1020);
    cyc(1'b1, 8'h10);
    cyc(1'b1, 8'h20);
    check("c no header no word", 32'(wv_c), 32'd0);
    cyc(1'b1, 8'hA5);
    repeat (49) cyc(1'b0, 8'h00);
    check("c header not yet timed out", 32'(to_c), 32'd0);
    cyc(1'b0, 8'h00);
    check("c header timeout", 32'(to_c), 32'd1);
    check("c busy after timeout", 32'(busy_c), 32'd0);

    // Inter-byte timeout on A
    do_reset();
    cyc(1'b1, 8'hAB);
    check("to busy", 32'(busy_a), 32'd1);
    saw = 1'b0;
    repeat (49) begin
      cyc(1'b0, 8'h00);
      if (to_a) saw = 1'b1;
    end
    check("to early", 32'(saw), 32'd0);
    check("to busy before", 32'(busy_a), 32'd1);
    cyc(1'b0, 8'h00);
    check("to pulse", 32'(to_a), 32'd1);
    check("to busy after", 32'(busy_a), 32'd0);
    cyc(1'b0, 8'h00);
    check("to pulse one cycle", 32'(to_a), 32'd0);
    cyc(1'b1, 8'hCD);
    cyc(1'b1, 8'hEF);
    check("to next valid", 32'(wv_a), 32'd1);
    check("to next data", 32'(wd_a), 32'hCDEF);
    // A byte landing in the expiry cycle wins
    do_reset();
    cyc(1'b1, 8'h11);
    repeat (49) cyc(1'b0, 8'h00);
    cyc(1'b1, 8'h22);
    check("byte wins no to", 32'(to_a), 32'd0);
    check("byte wins data", 32'(wd_a), 32'h1122);

    // Full FIFO, overflow, clear, drain
    do_reset();
    for (int w = 0; w < 6; w++) begin
      cyc(1'b1, 8'(8'hA0 + w));
      cyc(1'b1, 8'(8'hB0 + w));
    end
    check("ovf valid", 32'(wv_a), 32'd1);
    check("ovf flag", 32'(ovf_a), 32'd1);
    check("ovf drop_cnt", 32'(dc_a), 32'd2);
    check("ovf head", 32'(wd_a), 32'hA0B0);
    clear = 1'b1;
    cyc(1'b0, 8'h00);
    clear = 1'b0;
    check("clear ovf", 32'(ovf_a), 32'd0);
    check("clear drop_cnt", 32'(dc_a), 32'd0);
    check("clear keeps fifo", 32'(wv_a), 32'd1);
    word_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("drain%0d", k), 32'(wd_a), 32'({8'(8'hA0 + k), 8'(8'hB0 + k)}));
      cyc(1'b0, 8'h00);
    end
    check("drain empty", 32'(wv_a), 32'd0);
    // Drop in the same cycle as clear
    word_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 8'(8'hC0 + k));
      cyc(1'b1, 8'(8'hD0 + k));
    end
    cyc(1'b1, 8'hE0);
    clear = 1'b1;
    cyc(1'b1, 8'hE1);
    clear = 1'b0;
    check("clr+drop ovf", 32'(ovf_a), 32'd1);
    check("clr+drop cnt", 32'(dc_a), 32'd1);
    // Push into a full FIFO with a same-cycle pop is accepted
    cyc(1'b1, 8'h5A);
    word_ready = 1'b1;
    cyc(1'b1, 8'h5B);
    check("push+pop cnt", 32'(dc_a), 32'd1);
    check("push+pop head", 32'(wd_a), 32'hC1D1);
    cyc(1'b0, 8'h00);
    check("push+pop d2", 32'(wd_a), 32'hC2D2);
    cyc(1'b0, 8'h00);
    check("push+pop d3", 32'(wd_a), 32'hC3D3);
    cyc(1'b0, 8'h00);
    check("push+pop new", 32'(wd_a), 32'h5A5B);
    cyc(1'b0, 8'h00);
    check("push+pop empty", 32'(wv_a), 32'd0);

    // Reset mid-frame with words buffered
    do_reset();
    cyc(1'b1, 8'h31); cyc(1'b1, 8'h41);
    cyc(1'b1, 8'h59); cyc(1'b1, 8'h26);
    cyc(1'b1, 8'h53);
    check("pre-rst busy", 32'(busy_a), 32'd1);
    check("pre-rst valid", 32'(wv_a), 32'd1);
    do_reset();
    check("midrst valid", 32'(wv_a), 32'd0);
    check("midrst data", 32'(wd_a), 32'd0);
    check("midrst busy", 32'(busy_a), 32'd0);
    check("midrst ovf", 32'(ovf_a), 32'd0);
    word_ready = 1'b1;
    cyc(1'b1, 8'h56);
    cyc(1'b1, 8'h78);
    check("post-rst data", 32'(wd_a), 32'h5678);
    check("post-rst valid", 32'(wv_a), 32'd1);

    // Randomized traffic on A against the reference model
    do_reset();
    m_part.delete();
    m_q.delete();
    m_idle = 0;
    m_to   = 1'b0;
    m_ovf  = 1'b0;
    m_drop = 0;
    for (int ph = 0; ph < 4; ph++) begin
      case (ph)
        0:       begin pv = 60; pr = 70; end
        1:       begin pv = 5;  pr = 20; end
        2:       begin pv = 1;  pr = 50; end
        default: begin pv = 30; pr = 5;  end
      endcase
      for (int n = 0; n < 800; n++) begin
        check("rnd valid", 32'(wv_a), 32'(m_q.size() > 0));
        if (m_q.size() > 0) check("rnd data", 32'(wd_a), 32'(m_q[0]));
        check("rnd busy", 32'(busy_a), 32'(m_part.size() > 0));
        check("rnd timeout", 32'(to_a), 32'(m_to));
        check("rnd overflow", 32'(ovf_a), 32'(m_ovf));
        check("rnd drop_cnt", 32'(dc_a), 32'(m_drop));
        rx_valid   = ($urandom_range(99) < pv);
        rx_data    = 8'($urandom);
        word_ready = ($urandom_range(99) < pr);
        clear      = ($urandom_range(99) < 2);
        @(posedge clk);
        model_step(rx_valid, rx_data, word_ready, clear);
        #1;
      end
    end
    rx_valid = 1'b0;
    clear    = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_word_assembler.md
Name: uart_word_assembler

Overview:
Parametrised successor to the fixed 8-to-16-bit UART byte concatenator.
- Collects single-cycle UART byte strobes into words of BYTES_PER_WORD bytes, with selectable byte order.
- Optional sync-byte framing and inter-byte timeout resynchronisation.
- Completed words are buffered in a small FIFO and offered on a valid/ready interface to the trading-algorithm block.
- Sits between the UART receiver and the algorithm core, replacing the 16-bit concatenator.

Parameters:
BYTES_PER_WORD, 2, bytes per assembled word; legal range 2..4.
MSB_FIRST, 1, 1 = first received byte is most significant; 0 = first byte is least significant.
SYNC_EN, 0, 1 = every word must be preceded by SYNC_BYTE.
SYNC_BYTE, 8'hA5, frame header value; used only when SYNC_EN=1.
TIMEOUT_CYC, 100000, idle cycles before a partial word is discarded; 0 disables the timeout.
FIFO_DEPTH, 4, output word buffer depth; power of 2, minimum 2.

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
rx_data  in  8  received UART byte
rx_valid  in  1  one-cycle strobe; rx_data is valid this cycle
clear  in  1  synchronous clear of overflow and drop_cnt
word_data  out  8*BYTES_PER_WORD  FIFO head word
word_valid  out  1  FIFO not empty
word_ready  in  1  consumer accepts word_data this cycle
busy  out  1  partial word in progress, or header received
timeout_err  out  1  one-cycle pulse when a partial frame is discarded
overflow  out  1  sticky; a completed word was dropped because the FIFO was full
drop_cnt  out  8  saturating count of dropped words

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - FIFO emptied, byte count = 0, shift register = 0, timer = 0.
  - word_valid=0, word_data=0, busy=0, timeout_err=0, overflow=0, drop_cnt=0.
  - State = HUNT if SYNC_EN=1, else COLLECT.
  - Reset mid-frame discards the partial word and all buffered words.
- States:
  - HUNT: rx_valid with rx_data==SYNC_BYTE -> COLLECT with count=0. Any other byte is ignored. The sync byte is never part of the word.
  - COLLECT: each rx_valid stores the byte at index count and increments count.
    - MSB_FIRST=1: byte k lands at bits [8*(BYTES_PER_WORD-k)-1 -: 8].
    - MSB_FIRST=0: byte k lands at bits [8*k+7 -: 8].
    - On the last byte (count==BYTES_PER_WORD-1) the complete word, including that byte, is pushed the same cycle. count -> 0. State -> HUNT if SYNC_EN=1, else stays COLLECT.
- busy:
  - 1 while in COLLECT with count>0.
  - With SYNC_EN=1, also 1 in COLLECT with count=0 (header received).
- Timer:
  - Runs only while busy=1. Cleared on every rx_valid and whenever busy=0.
  - On reaching TIMEOUT_CYC: partial word discarded, count -> 0, state -> HUNT (SYNC_EN=1) or COLLECT (SYNC_EN=0), one-cycle timeout_err pulse.
  - If rx_valid arrives in the same cycle the timer expires, the byte wins and no timeout occurs.
- Latency: word_valid rises on the clk edge after the final byte's rx_valid when the FIFO was empty (1 cycle).
- Output handshake:
  - word_valid = FIFO not empty; a pop occurs when word_valid && word_ready.
  - word_data and word_valid must hold stable while word_valid && !word_ready.
  - word_data is don't-care while word_valid=0.
- Full FIFO:
  - A push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the word is dropped: overflow -> 1 (sticky), drop_cnt increments and saturates at 255.
  - Same-cycle push and pop on a non-full FIFO keeps the occupancy unchanged.
- clear:
  - Zeroes overflow and drop_cnt.
  - If a drop occurs in the same cycle as clear, the result is overflow=1, drop_cnt=1.
- rx_valid in back-to-back cycles must be accepted without loss.

Decomposition:
- Shared package uart_asm_pkg:
  - state enum {HUNT, COLLECT}.
  - localparam function clog2 for count and FIFO pointer widths.
  - Default SYNC_BYTE constant.
- One natural sub-module: word_fifo. Synchronous FIFO with parameters WIDTH and DEPTH. Signals: push, pop, full, empty; first-word-fall-through head output.
- The assembler FSM, timer and counters live in the top of the block.

Test Plan:
1. BPW=2, MSB_FIRST=1: bytes 0x12, 0x34 with word_ready=1 -> word_data=16'h1234, word_valid high for 1 cycle, starting 1 cycle after the 2nd byte.
2. BPW=4, MSB_FIRST=0: bytes 01,02,03,04 back-to-back -> word_data=32'h04030201.
3. SYNC_EN=1: bytes 0x77, 0xA5, 0x10, 0x20 -> single word 16'h1020; the 0x77 is ignored; busy=1 from the 0xA5 until the 0x20.
4. TIMEOUT_CYC=50: byte 0xAB, then idle 50 cycles -> timeout_err pulse, busy=0. Following bytes 0xCD, 0xEF -> word 16'hCDEF.
5. FIFO_DEPTH=4, word_ready=0, 6 words sent -> 4 buffered, overflow=1, drop_cnt=2. Then pulse clear -> drop_cnt=0. Then drain -> the 4 words come out in order.
6. reset_n=0 asserted after 1 byte of a frame with 2 words buffered -> all outputs 0, FIFO empty. Next full frame is assembled correctly.
